// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with registered status flags,
// optional first-word-fall-through output and over/underflow pulses.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       DATA_IN,
  input  logic                   write,
  input  logic                   read,
  input  logic                   flush,
  output logic [WIDTH-1:0]       DATA_OUT,
  output logic                   empty,
  output logic                   full,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_acc;
  logic             wr_acc;
  logic [CW-1:0]    count_nx;

  // A write into a full FIFO is allowed only if a read frees a slot
  always_comb begin
    rd_acc   = read && !empty;
    wr_acc   = write && (!full || rd_acc);
    count_nx = count;
    if (wr_acc && !rd_acc)
      count_nx = count + CW'(1);
    else if (rd_acc && !wr_acc)
      count_nx = count - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset && wr_acc && !flush)
      mem[wr_ptr] <= DATA_IN;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_full  <= (AF_C == '0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc)
        rd_ptr <= rd_ptr + AW'(1);
      count        <= count_nx;
      empty        <= (count_nx == '0);
      full         <= (count_nx == FULL_C);
      almost_full  <= (count_nx >= AF_C);
      almost_empty <= (count_nx <= AE_C);
      overflow     <= write && !wr_acc;
      underflow    <= read && !rd_acc;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign DATA_OUT = empty ? '0 : mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;
      always_ff @(posedge clock or negedge reset) begin
        if (!reset)
          dout_q <= '0;
        else if (flush)
          dout_q <= '0;
        else if (rd_acc)
          dout_q <= mem[rd_ptr];
      end
      assign DATA_OUT = dout_q;
    end
  endgenerate

endmodule
